// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the transmitter and the receiver.
package i2s_pkg;

  // Slot counter width; covers frames of up to 256 SCLK periods (DATA_BIT <= 128).
  localparam int SLOT_W = 8;

  // Widest sample either side of the link carries; narrower samples are zero-extended.
  localparam int AUDIO_MAX_W = 32;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef struct packed {
    logic [AUDIO_MAX_W-1:0] l;
    logic [AUDIO_MAX_W-1:0] r;
  } audio_pair_t;

  // SCLK periods per stereo frame.
  function automatic int frame_bits(input int data_bit);
    return 2 * data_bit;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit/word clock generator: divides the system clock down to SCLK,
// tracks the slot within the frame and flags the falling-edge and load events.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int DATA_BIT = 16,
  parameter int SCLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_lrclk,
  output logic o_fe,
  output logic o_load
);

  localparam int FRAME = frame_bits(DATA_BIT);
  localparam int DIV_W = $clog2(SCLK_DIV);

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t  DIV_LAST  = div_t'(SCLK_DIV - 1);
  localparam div_t  DIV_HALF  = div_t'(SCLK_DIV / 2);
  localparam slot_t SLOT_LAST = slot_t'(FRAME - 1);
  localparam slot_t SLOT_HALF = slot_t'(DATA_BIT);

  div_t  div_cnt_q, div_cnt_d;
  slot_t slot_q, slot_d;
  logic  sclk_q, sclk_d;
  logic  lrclk_q, lrclk_d;
  logic  fe;

  // Next-state for divider and slot; disabling parks both at zero so a
  // re-enable always restarts cleanly at slot 0. SCLK/LRCLK are computed from
  // the next counter values so the registered clocks line up with the counters.
  always_comb begin
    fe        = i_en && (div_cnt_q == DIV_LAST);
    div_cnt_d = '0;
    slot_d    = '0;
    if (i_en) begin
      div_cnt_d = fe ? '0 : div_cnt_q + 1'b1;
      slot_d    = slot_q;
      if (fe) begin
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end
    end
    sclk_d  = i_en && (div_cnt_d >= DIV_HALF);
    lrclk_d = i_en && (slot_d >= SLOT_HALF);
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt_q <= '0;
      slot_q    <= '0;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
      sclk_q    <= sclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign o_sclk  = sclk_q;
  assign o_lrclk = lrclk_q;
  assign o_fe    = fe;
  // The FE leaving slot 0 is where a new pair enters the shifter.
  assign o_load  = fe && (slot_q == '0);

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-deep valid/ready sample buffer feeding a
// frame-wide shifter that drives SD MSB-first, one SCLK after the LRCLK edge.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_BIT = 16,
  parameter int SCLK_DIV = 8
) (
  input  logic                i_clk_12_288,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic [DATA_BIT-1:0] i_audio_l,
  input  logic [DATA_BIT-1:0] i_audio_r,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_sclk,
  output logic                o_lrclk,
  output logic                o_sd,
  output logic                o_frame_start,
  output logic                o_underrun
);

  localparam int FRAME = frame_bits(DATA_BIT);

  logic fe;
  logic load;
  logic accept;

  logic                full_q, full_d;
  logic [DATA_BIT-1:0] buf_l_q, buf_l_d;
  logic [DATA_BIT-1:0] buf_r_q, buf_r_d;
  logic [DATA_BIT-1:0] last_l_q, last_l_d;
  logic [DATA_BIT-1:0] last_r_q, last_r_d;
  logic [FRAME-1:0]    shift_q, shift_d;
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;

  i2s_clk_gen #(
    .DATA_BIT (DATA_BIT),
    .SCLK_DIV (SCLK_DIV)
  ) u_clk_gen (
    .i_clk   (i_clk_12_288),
    .i_reset (i_reset),
    .i_en    (i_en),
    .o_sclk  (o_sclk),
    .o_lrclk (o_lrclk),
    .o_fe    (fe),
    .o_load  (load)
  );

  // Buffer, shifter and status pulses. A load drains the buffer before the
  // handshake is looked at, so a pair arriving in the load cycle of an empty
  // buffer is held for the following frame while this frame repeats the last.
  always_comb begin
    accept        = i_valid && !full_q;
    full_d        = full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    last_l_d      = last_l_q;
    last_r_d      = last_r_q;
    shift_d       = shift_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (!i_en) begin
      shift_d = '0;
    end else if (load) begin
      frame_start_d = 1'b1;
      if (full_q) begin
        shift_d  = {buf_l_q, buf_r_q};
        last_l_d = buf_l_q;
        last_r_d = buf_r_q;
        full_d   = 1'b0;
      end else begin
        shift_d    = {last_l_q, last_r_q};
        underrun_d = 1'b1;
      end
    end else if (fe) begin
      shift_d = {shift_q[FRAME-2:0], 1'b0};
    end

    if (accept) begin
      buf_l_d = i_audio_l;
      buf_r_d = i_audio_r;
      full_d  = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk_12_288) begin
    if (i_reset) begin
      full_q        <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      last_l_q      <= '0;
      last_r_q      <= '0;
      shift_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      full_q        <= full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign o_ready       = !full_q;
  assign o_sd          = shift_q[FRAME-1];
  assign o_frame_start = frame_start_q;
  assign o_underrun    = underrun_q;

endmodule
